// File: rtl/aexm_icache_ctl_if.sv
// Core fetch port and refill memory port of the AEMB instruction cache.
//   slave  : the cache (consumes enable/adr/inv/mem_dat/mem_ack, drives datai/busy/mem_req/mem_adr)
//   master : the core fetch stage plus the instruction-side memory arbiter
interface aexm_icache_ctl_if;
  logic        aexm_icache_enable;
  logic [31:0] aexm_icache_adr;
  logic        aexm_icache_inv;
  logic [31:0] aexm_icache_datai;
  logic        aexm_icache_busy;
  logic        mem_req;
  logic [31:0] mem_adr;
  logic [31:0] mem_dat;
  logic        mem_ack;

  modport slave (
    input  aexm_icache_enable, aexm_icache_adr, aexm_icache_inv, mem_dat, mem_ack,
    output aexm_icache_datai, aexm_icache_busy, mem_req, mem_adr
  );

  modport master (
    output aexm_icache_enable, aexm_icache_adr, aexm_icache_inv, mem_dat, mem_ack,
    input  aexm_icache_datai, aexm_icache_busy, mem_req, mem_adr
  );
endinterface

// File: rtl/aexm_icache_ctl.sv
// Direct-mapped instruction cache controller for the AEMB fetch path.
// Lookup result (datai) one cycle after enable; a miss raises busy and
// refills the whole line over a req/ack memory port.
// Ports:
//   gclk, grst : clock, synchronous active-high reset
//   bus        : aexm_icache_ctl_if.slave (core fetch port + refill port)
// Build option: define AEXM_ICACHE_CRITWORD_EN for critical-word-first refill.
module aexm_icache_ctl #(
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned LINE_W = 2
) (
  input  logic              gclk,
  input  logic              grst,
  aexm_icache_ctl_if.slave  bus
);
  localparam int unsigned TAG_W  = 30 - IDX_W - LINE_W;
  localparam int unsigned NLINE  = 1 << IDX_W;
  localparam int unsigned NWORD  = 1 << (IDX_W + LINE_W);
  localparam int unsigned IDX_LO = LINE_W + 2;
  localparam int unsigned TAG_LO = IDX_W + LINE_W + 2;

  typedef enum logic [1:0] {FLUSH, IDLE, FILL, DONE} state_e;

  state_e              state_q, state_d;
  logic [31:0]         radr_q, radr_d;
  logic                look_q, look_d;     // a read was issued last cycle; compare is meaningful
  logic                pend_q, pend_d;     // invalidate seen during a fill
  logic [IDX_W-1:0]    fcnt_q, fcnt_d;
  logic [LINE_W-1:0]   wcnt_q, wcnt_d;
  logic                mem_req_q, mem_req_d;
  logic [31:0]         mem_adr_q, mem_adr_d;
  logic [31:0]         dat_q;
  logic [TAG_W-1:0]    tag_rd_q;
  logic                vld_rd_q;

  logic [31:0]         dram [NWORD];
  logic [TAG_W-1:0]    tram [NLINE];
  logic [NLINE-1:0]    vld_q;

  logic                rd_en_c, dwe_c, twe_c, vclr_c;
  logic [31:0]         rd_adr_c;
  logic [LINE_W-1:0]   start_c;
  logic                hit_c, miss_c, last_c, ack_c;
  logic                unused_c;

`ifdef AEXM_ICACHE_CRITWORD_EN
  assign start_c = radr_q[IDX_LO-1:2];
`else
  assign start_c = '0;
`endif

  assign hit_c    = vld_rd_q & (tag_rd_q == radr_q[31:TAG_LO]);
  assign miss_c   = (state_q == IDLE) & look_q & ~hit_c;
  assign ack_c    = mem_req_q & bus.mem_ack;
  // Counter wraps back onto the start word after the last word of the line.
  assign last_c   = (LINE_W'(wcnt_q + LINE_W'(1)) == start_c);
  assign rd_adr_c = (state_q == DONE) ? radr_q : bus.aexm_icache_adr;
  assign unused_c = ^{rd_adr_c[1:0], radr_q[1:0]};

  // State and control registers.
  always_ff @(posedge gclk) begin
    if (grst) begin
      state_q   <= FLUSH;
      radr_q    <= '0;
      look_q    <= 1'b0;
      pend_q    <= 1'b0;
      fcnt_q    <= '0;
      wcnt_q    <= '0;
      mem_req_q <= 1'b0;
      mem_adr_q <= '0;
    end else begin
      state_q   <= state_d;
      radr_q    <= radr_d;
      look_q    <= look_d;
      pend_q    <= pend_d;
      fcnt_q    <= fcnt_d;
      wcnt_q    <= wcnt_d;
      mem_req_q <= mem_req_d;
      mem_adr_q <= mem_adr_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    radr_d    = radr_q;
    look_d    = 1'b0;
    pend_d    = pend_q;
    fcnt_d    = fcnt_q;
    wcnt_d    = wcnt_q;
    mem_req_d = mem_req_q;
    mem_adr_d = mem_adr_q;
    rd_en_c   = 1'b0;
    dwe_c     = 1'b0;
    twe_c     = 1'b0;
    vclr_c    = 1'b0;
    unique case (state_q)
      FLUSH: begin
        vclr_c = 1'b1;
        pend_d = 1'b0;
        if (bus.aexm_icache_inv) begin
          fcnt_d = '0;
        end else if (fcnt_q == IDX_W'(NLINE - 1)) begin
          fcnt_d  = '0;
          state_d = IDLE;
        end else begin
          fcnt_d = IDX_W'(fcnt_q + IDX_W'(1));
        end
      end
      IDLE: begin
        if (bus.aexm_icache_inv) begin
          fcnt_d  = '0;
          state_d = FLUSH;
        end else if (miss_c) begin
          wcnt_d    = start_c;
          mem_req_d = 1'b1;
          mem_adr_d = {radr_q[31:IDX_LO], start_c, 2'b00};
          state_d   = FILL;
        end else if (bus.aexm_icache_enable) begin
          rd_en_c = 1'b1;
          look_d  = 1'b1;
          radr_d  = {bus.aexm_icache_adr[31:2], 2'b00};
        end
      end
      FILL: begin
        if (bus.aexm_icache_inv) pend_d = 1'b1;
        if (mem_req_q) begin
          if (ack_c) begin
            dwe_c     = 1'b1;
            wcnt_d    = LINE_W'(wcnt_q + LINE_W'(1));
            mem_adr_d = {radr_q[31:IDX_LO], LINE_W'(wcnt_q + LINE_W'(1)), 2'b00};
            if (last_c) begin
              twe_c     = 1'b1;
              mem_req_d = 1'b0;
            end
          end
        end else if (pend_q | bus.aexm_icache_inv) begin
          // Request has dropped: line is written, take the deferred flush.
          fcnt_d  = '0;
          state_d = FLUSH;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.aexm_icache_inv) begin
          fcnt_d  = '0;
          state_d = FLUSH;
        end else begin
          rd_en_c = 1'b1;
          look_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = FLUSH;
    endcase
  end

  // Synchronous lookup read; dat_q is the word presented to the core.
  always_ff @(posedge gclk) begin
    if (grst) begin
      dat_q    <= '0;
      tag_rd_q <= '0;
      vld_rd_q <= 1'b0;
    end else if (rd_en_c) begin
      dat_q    <= dram[rd_adr_c[TAG_LO-1:2]];
      tag_rd_q <= tram[rd_adr_c[TAG_LO-1:IDX_LO]];
      vld_rd_q <= vld_q[rd_adr_c[TAG_LO-1:IDX_LO]];
    end
  end

  // Data and tag RAM writes.
  always_ff @(posedge gclk) begin
    if (dwe_c) dram[{radr_q[TAG_LO-1:IDX_LO], wcnt_q}] <= bus.mem_dat;
    if (twe_c) tram[radr_q[TAG_LO-1:IDX_LO]] <= radr_q[31:TAG_LO];
  end

  // Valid bits: cleared one per cycle while flushing, set on line completion.
  always_ff @(posedge gclk) begin
    if (vclr_c)     vld_q[fcnt_q] <= 1'b0;
    else if (twe_c) vld_q[radr_q[TAG_LO-1:IDX_LO]] <= 1'b1;
  end

  assign bus.aexm_icache_datai = dat_q;
  assign bus.aexm_icache_busy  = (state_q != IDLE) | miss_c;
  assign bus.mem_req           = mem_req_q;
  assign bus.mem_adr           = mem_adr_q;
endmodule

// File: tb/tb_aexm_icache_ctl.sv
// Randomized self-checking bench for aexm_icache_ctl against a line-level
// cache model (valid/tag arrays, per-address data function).
module tb_aexm_icache_ctl;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned LINE_W = 2;
  localparam int unsigned NLINE  = 1 << IDX_W;
  localparam int         BOUND   = 1000;

  logic gclk = 1'b0;
  logic grst;
  always #5 gclk = ~gclk;

  aexm_icache_ctl_if bus ();

  aexm_icache_ctl #(.IDX_W(IDX_W), .LINE_W(LINE_W)) dut (
    .gclk (gclk),
    .grst (grst),
    .bus  (bus.slave)
  );

  int vec = 0;
  int err = 0;

  bit          mv [NLINE];
  logic [21:0] mt [NLINE];
  logic [31:0] ackq [$];
  int          fillc;
  bit          zero_wait;
  bit          crit;
  logic [31:0] last_word;

  function automatic logic [31:0] word(input logic [31:0] a);
    logic [31:0] w;
    w = {2'b00, a[31:2]};
    return (w * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] exp_adr(input logic [31:0] a, input int k);
    int off;
    off = crit ? ((int'(a[3:2]) + k) % 4) : k;
    return {a[31:4], 4'(off << 2)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(NLINE); i++) mv[i] = 1'b0;
  endtask

  // Memory side: acks and data, plus address-stability check while waiting.
  initial begin : responder
    bit          ack;
    bit          prev_wait;
    logic [31:0] prev_adr;
    prev_wait = 1'b0;
    prev_adr  = '0;
    bus.mem_ack = 1'b0;
    bus.mem_dat = '0;
    forever begin
      @(negedge gclk);
      if (bus.mem_req === 1'b1) begin
        fillc++;
        if (prev_wait) chk("mem_adr_stable", bus.mem_adr, prev_adr);
        ack = zero_wait || ($urandom_range(0, 1) == 1);
        bus.mem_ack = ack;
        bus.mem_dat = ack ? word(bus.mem_adr) : $urandom;
        if (ack) ackq.push_back(bus.mem_adr);
      end else begin
        ack = 1'b0;
        // Stray acks while no request must be ignored.
        bus.mem_ack = zero_wait ? 1'b0 : 1'($urandom_range(0, 1));
        bus.mem_dat = $urandom;
      end
      prev_wait = (bus.mem_req === 1'b1) && !ack;
      prev_adr  = bus.mem_adr;
    end
  end

  // One-cycle lookup strobe; returns at the compare-cycle negedge.
  task automatic issue(input logic [31:0] a);
    @(negedge gclk);
    bus.aexm_icache_enable = 1'b1;
    bus.aexm_icache_adr    = a;
    ackq.delete();
    fillc = 0;
    @(negedge gclk);
    bus.aexm_icache_enable = 1'b0;
  endtask

  // Count consecutive busy cycles from the current negedge; inv pulsed at cycle inv_at.
  task automatic run(input int inv_at, output int n);
    int i;
    i = 0;
    n = 0;
    forever begin
      bus.aexm_icache_inv = (i == inv_at);
      if (bus.aexm_icache_busy !== 1'b1) break;
      if (n >= BOUND) begin
        chk("busy_timeout", 32'(n), 32'(BOUND + 1));
        break;
      end
      n++;
      i++;
      @(negedge gclk);
    end
  endtask

  // Full lookup checked against the model; returns busy-cycle count.
  task automatic lookup(input logic [31:0] a, output int n);
    int          idx;
    logic [21:0] tg;
    bit          hit;
    idx = int'(a[9:4]);
    tg  = a[31:10];
    hit = mv[idx] && (mt[idx] == tg);
    issue(a);
    run(-1, n);
    if (hit) begin
      chk("hit_busy_cycles", 32'(n), 32'd0);
      chk("hit_no_fill", 32'(fillc), 32'd0);
    end else begin
      chk("miss_busy_cycles", 32'(n), 32'(fillc + 3));
      chk("miss_ack_count", 32'(ackq.size()), 32'd4);
      if (ackq.size() == 4)
        for (int k = 0; k < 4; k++) chk("miss_fill_adr", ackq[k], exp_adr(a, k));
      mv[idx] = 1'b1;
      mt[idx] = tg;
    end
    chk("datai", bus.aexm_icache_datai, word(a));
    last_word = word(a);
  endtask

  // Enable held low with a wandering address: output must hold, no activity.
  task automatic hold(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge gclk);
      bus.aexm_icache_adr = $urandom;
      chk("hold_datai", bus.aexm_icache_datai, last_word);
      chk("hold_busy", 32'(bus.aexm_icache_busy), 32'd0);
      chk("hold_mem_req", 32'(bus.mem_req), 32'd0);
    end
  endtask

  initial begin : main
    int n;
    logic [31:0] a;
`ifdef AEXM_ICACHE_CRITWORD_EN
    crit = 1'b1;
`else
    crit = 1'b0;
`endif
    zero_wait = 1'b1;
    fillc = 0;
    last_word = '0;
    model_clear();
    grst = 1'b1;
    bus.aexm_icache_enable = 1'b0;
    bus.aexm_icache_adr    = '0;
    bus.aexm_icache_inv    = 1'b0;

    // Reset values and power-up flush length.
    repeat (3) @(negedge gclk);
    chk("rst_busy", 32'(bus.aexm_icache_busy), 32'd1);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_adr", bus.mem_adr, 32'd0);
    chk("rst_datai", bus.aexm_icache_datai, 32'd0);
    grst = 1'b0;
    run(-1, n);
    chk("flush_cycles", 32'(n), 32'd64);
    chk("flush_datai", bus.aexm_icache_datai, 32'd0);

    // Cold fetch, zero-wait fill, literal order.
    lookup(32'h0000_0104, n);
    chk("cold_busy_7", 32'(n), 32'd7);
    if (ackq.size() == 4) begin
      chk("cold_adr0", ackq[0], crit ? 32'h104 : 32'h100);
      chk("cold_adr3", ackq[3], crit ? 32'h100 : 32'h10C);
    end
    chk("cold_datai_lit", bus.aexm_icache_datai, word(32'h104));

    // Hits in the filled line, then hold with enable low.
    lookup(32'h0000_0108, n);
    chk("hit108_busy", 32'(n), 32'd0);
    lookup(32'h0000_010C, n);
    chk("hit10c_busy", 32'(n), 32'd0);
    hold(5);

    // Conflict in the same index evicts the first line.
    lookup(32'h0000_1104, n);
    chk("conflict_busy_7", 32'(n), 32'd7);
    lookup(32'h0000_0104, n);
    chk("refetch_busy_7", 32'(n), 32'd7);

    // Hit coinciding with inv still returns data; flush follows.
    issue(32'h0000_0104);
    run(0, n);
    chk("inv_hit_busy", 32'(n), 32'd0);
    chk("inv_hit_datai", bus.aexm_icache_datai, word(32'h104));
    @(negedge gclk);
    bus.aexm_icache_inv = 1'b0;
    run(-1, n);
    chk("inv_hit_flush", 32'(n), 32'd64);
    model_clear();

    // inv during the second ack: fill completes, then flush instead of DONE.
    issue(32'h0000_0104);
    run(2, n);
    chk("inv_fill_acks", 32'(ackq.size()), 32'd4);
    chk("inv_fill_busy", 32'(n), 32'(1 + 4 + 1 + 64));
    model_clear();
    lookup(32'h0000_0104, n);
    chk("after_inv_miss", 32'(n), 32'd7);

    // Reset mid-fill leaves the partial line invalid.
    issue(32'h0000_0208);
    @(negedge gclk);
    @(negedge gclk);
    grst = 1'b1;
    @(negedge gclk);
    grst = 1'b0;
    chk("rst_fill_req", 32'(bus.mem_req), 32'd0);
    run(-1, n);
    chk("rst_fill_flush", 32'(n), 32'd64);
    model_clear();
    lookup(32'h0000_0208, n);
    chk("rst_fill_miss", 32'(n), 32'd7);

    // Random traffic over a small address pool with random ack waits.
    zero_wait = 1'b0;
    for (int t = 0; t < 250; t++) begin
      a = {20'(($urandom_range(0, 2)) << 0), 2'b00, 6'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      lookup(a, n);
      if ($urandom_range(0, 7) == 0) hold(int'($urandom_range(1, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
